// File: rtl/fpga_status_led_pkg.sv
// Shared types and constants for the FPGA status LED controller and its channels.
package fpga_status_led_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'b00,
        LED_ON      = 2'b01,
        LED_BLINK   = 2'b10,
        LED_STRETCH = 2'b11
    } led_mode_e;

    typedef logic [1:0] led_rate_t;

    localparam led_rate_t EXIT_FAIL_RATE = 2'd3;

    // src[3] is the prescaler MSB; a higher rate picks a lower (faster) bit.
    function automatic logic blink_pick(input logic [3:0] src, input led_rate_t rate);
        return src[2'd3 - rate];
    endfunction

endpackage

// File: rtl/status_led_channel.sv
// One LED channel: mode/rate registers, event stretch counter and lit-state mux.
module status_led_channel
    import fpga_status_led_pkg::*;
#(
    parameter int        STRETCH_WIDTH = 20,
    parameter led_mode_e RESET_MODE    = LED_OFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_we_i,
    input  led_mode_e   cfg_mode_i,
    input  led_rate_t   cfg_rate_i,
    input  logic        event_i,
    input  logic [3:0]  blink_src_i,
    output logic        lit_o
);

    led_mode_e                mode_q;
    led_rate_t                rate_q;
    logic [STRETCH_WIDTH-1:0] stretch_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q <= RESET_MODE;
            rate_q <= '0;
        end else if (cfg_we_i) begin
            mode_q <= cfg_mode_i;
            rate_q <= cfg_rate_i;
        end
    end

    // Runs in every mode so switching to STRETCH shows an in-flight pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stretch_q <= '0;
        end else if (event_i) begin
            stretch_q <= '1;
        end else if (stretch_q != '0) begin
            stretch_q <= stretch_q - STRETCH_WIDTH'(1);
        end
    end

    // NOTE: default assigned first so no path through the case can infer a latch.
    always_comb begin
        lit_o = 1'b0;
        unique case (mode_q)
            LED_OFF:     lit_o = 1'b0;
            LED_ON:      lit_o = 1'b1;
            LED_BLINK:   lit_o = blink_pick(blink_src_i, rate_q);
            LED_STRETCH: lit_o = (stretch_q != '0);
            default:     lit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpga_status_led_ctrl.sv
// Board status LED controller: prescaler, per-channel LEDs, sticky exit override on channel 0.
// Optional global PWM dimming when STATUS_LED_PWM_EN is defined.
module fpga_status_led_ctrl
    import fpga_status_led_pkg::*;
#(
    parameter int NUM_LEDS      = 4,
    parameter int CNT_WIDTH     = 27,
    parameter int STRETCH_WIDTH = 20
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cfg_we_i,
    input  logic [$clog2(NUM_LEDS)-1:0] cfg_ch_i,
    input  logic [1:0]                  cfg_mode_i,
    input  logic [1:0]                  cfg_rate_i,
    input  logic [NUM_LEDS-1:0]         event_i,
    input  logic                        exit_valid_i,
    input  logic [31:0]                 exit_value_i,
    input  logic [3:0]                  brightness_i,
    output logic [NUM_LEDS-1:0]         led_o,
    output logic                        heartbeat_o,
    output logic                        exit_latched_o
);

    localparam int CH_W = $clog2(NUM_LEDS);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [3:0]           blink_src;
    logic                 exit_valid_prev_q;
    logic                 exit_latched_q;
    logic                 exit_fail_q;
    logic [NUM_LEDS-1:0]  lit;
    logic [NUM_LEDS-1:0]  led_next;
    logic [NUM_LEDS-1:0]  led_d;
    logic [NUM_LEDS-1:0]  led_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign heartbeat_o = cnt_q[CNT_WIDTH-1];
    assign blink_src   = cnt_q[CNT_WIDTH-1 -: 4];

    // First rising edge of exit_valid_i wins; the verdict stays until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exit_valid_prev_q <= 1'b0;
            exit_latched_q    <= 1'b0;
            exit_fail_q       <= 1'b0;
        end else begin
            exit_valid_prev_q <= exit_valid_i;
            if (exit_valid_i && !exit_valid_prev_q && !exit_latched_q) begin
                exit_latched_q <= 1'b1;
                exit_fail_q    <= (exit_value_i != 32'd0);
            end
        end
    end

    assign exit_latched_o = exit_latched_q;

    for (genvar k = 0; k < NUM_LEDS; k++) begin : g_ch
        status_led_channel #(
            .STRETCH_WIDTH (STRETCH_WIDTH),
            .RESET_MODE    ((k == 0) ? LED_BLINK : LED_OFF)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .cfg_we_i    (cfg_we_i && (cfg_ch_i == CH_W'(k))),
            .cfg_mode_i  (led_mode_e'(cfg_mode_i)),
            .cfg_rate_i  (cfg_rate_i),
            .event_i     (event_i[k]),
            .blink_src_i (blink_src),
            .lit_o       (lit[k])
        );
    end

    always_comb begin
        led_next = lit;
        if (exit_latched_q) begin
            led_next[0] = exit_fail_q ? blink_pick(blink_src, EXIT_FAIL_RATE) : 1'b1;
        end
    end

`ifdef STATUS_LED_PWM_EN
    logic [3:0] frame_q;
    logic       pwm_on;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_q + 4'd1;
        end
    end

    // Full-scale brightness must never drop a frame.
    assign pwm_on = (brightness_i == 4'hF) || (frame_q < brightness_i);
    assign led_d  = led_next & {NUM_LEDS{pwm_on}};
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness_i;
    assign led_d             = led_next;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// Directed self-checking bench for fpga_status_led_ctrl (small prescaler/stretch widths).
module tb_fpga_status_led_ctrl;

    localparam int NL = 5;
    localparam int CW = 6;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_ch = '0;
    logic [1:0]    cfg_mode = '0;
    logic [1:0]    cfg_rate = '0;
    logic [NL-1:0] ev = '0;
    logic          exit_valid = 1'b0;
    logic [31:0]   exit_value = '0;
    logic [3:0]    brightness = 4'hF;
    logic [NL-1:0] led;
    logic          hb;
    logic          exit_latched;

    int n_checks = 0;
    int n_fail   = 0;
    int e        = 0;

    fpga_status_led_ctrl #(
        .NUM_LEDS      (NL),
        .CNT_WIDTH     (CW),
        .STRETCH_WIDTH (SW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cfg_we_i       (cfg_we),
        .cfg_ch_i       (cfg_ch),
        .cfg_mode_i     (cfg_mode),
        .cfg_rate_i     (cfg_rate),
        .event_i        (ev),
        .exit_valid_i   (exit_valid),
        .exit_value_i   (exit_value),
        .brightness_i   (brightness),
        .led_o          (led),
        .heartbeat_o    (hb),
        .exit_latched_o (exit_latched)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [1:0] mode, input logic [1:0] rate);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_mode = mode;
        cfg_rate = rate;
        tick();
        cfg_we   = 1'b0;
    endtask

    initial begin
        int cnt;
        int bad;

        repeat (5) @(posedge clk);
        #1;
        check("rst_led", 32'(led), 32'd0);
        check("rst_hb", 32'(hb), 32'd0);
        check("rst_exit", 32'(exit_latched), 32'd0);

        // Edge n after release leaves the prescaler at n; led_o lags the prescaler by one edge.
        rst = 1'b0;
        e = 0;
        for (int i = 0; i < 128; i++) begin
            tick();
            check("heartbeat", 32'(hb), 32'((e % 64) >= 32));
            check("led0_blink", 32'(led[0]), 32'(((e - 1) % 64) >= 32));
        end

        cfg_write(3'd2, 2'b01, 2'd0);
        check("ch2_on_after_1_edge", 32'(led[2]), 32'd0);
        tick();
        check("ch2_on_after_2_edges", 32'(led[2]), 32'd1);

        cfg_write(3'd5, 2'b01, 2'd0);
        tick();
        tick();
        check("oob_write_ch1_4", 32'(led[4:1]), 32'b0010);
        check("oob_write_ch0", 32'(led[0]), 32'(((e - 1) % 64) >= 32));

`ifdef STATUS_LED_PWM_EN
        brightness = 4'd4;
        tick();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            cnt += int'(led[2]);
        end
        check("pwm_duty_4", 32'(cnt), 32'd4);
        brightness = 4'd0;
        tick();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            cnt += int'(led[2]);
        end
        check("pwm_duty_0", 32'(cnt), 32'd0);
        brightness = 4'hF;
        tick();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            cnt += int'(led[2]);
        end
        check("pwm_duty_15", 32'(cnt), 32'd16);
`else
        brightness = 4'd0;
        tick();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            cnt += int'(led[2]);
        end
        check("brightness_ignored", 32'(cnt), 32'd16);
        brightness = 4'hF;
`endif

        cfg_write(3'd1, 2'b11, 2'd0);
        tick();
        check("stretch_idle", 32'(led[1]), 32'd0);

        ev[1] = 1'b1;
        tick();
        ev[1] = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            cnt += int'(led[1]);
        end
        check("stretch_single_len", 32'(cnt), 32'd7);

        ev[1] = 1'b1;
        tick();
        ev[1] = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 4) ev[1] = 1'b1;
            tick();
            ev[1] = 1'b0;
            cnt += int'(led[1]);
        end
        check("stretch_retrigger_len", 32'(cnt), 32'd11);

        // Same-edge config write and event on channel 3.
        cfg_we   = 1'b1;
        cfg_ch   = 3'd3;
        cfg_mode = 2'b11;
        cfg_rate = 2'd0;
        ev[3]    = 1'b1;
        tick();
        cfg_we   = 1'b0;
        ev[3]    = 1'b0;
        check("cfg_event_same_edge_1", 32'(led[3]), 32'd0);
        tick();
        check("cfg_event_same_edge_2", 32'(led[3]), 32'd1);

        exit_value = 32'd0;
        exit_valid = 1'b1;
        tick();
        check("exit_latched_pass", 32'(exit_latched), 32'd1);
        cfg_write(3'd0, 2'b00, 2'd0);
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            if (i == 10) exit_valid = 1'b0;
            if (i == 20) begin
                exit_value = 32'd5;
                exit_valid = 1'b1;
            end
            tick();
            if (led[0] !== 1'b1) bad++;
        end
        check("exit_pass_led0_const", 32'(bad), 32'd0);
        check("exit_still_latched", 32'(exit_latched), 32'd1);

        ev[1] = 1'b1;
        tick();
        ev[1] = 1'b0;
        tick();
        check("pre_rst_led1", 32'(led[1]), 32'd1);
        check("pre_rst_led0", 32'(led[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_led", 32'(led), 32'd0);
        check("async_rst_hb", 32'(hb), 32'd0);
        check("async_rst_exit", 32'(exit_latched), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        e = 0;
        exit_value = 32'd5;
        exit_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (e == 1) check("exit_latched_fail", 32'(exit_latched), 32'd1);
            if (e >= 2) check("exit_fail_blink", 32'(led[0]), 32'(((e - 1) >> 2) & 1));
        end
        cfg_write(3'd0, 2'b01, 2'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            check("exit_fail_ignores_cfg", 32'(led[0]), 32'(((e - 1) >> 2) & 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
